sync_debounce: RTL and testbench
================================

Name: sync_debounce

Overview:
- Multi-channel input conditioner for asynchronous inputs such as buttons, switches and external strobes.
- Each channel passes through a parametrised-depth synchronizer, then a stability-qualified debouncer, then an edge detector.
- Provides clean levels and single-cycle rise/fall pulses to logic in the clk domain.
- Next generation of the 2/3-stage synchronizers: adds per-channel reset values, configurable stage count, debounce and edge outputs.

Parameters:
- WIDTH, 1, number of independent channels.
- STAGES, 2, synchronizer depth; legal range 2..4.
- DEBOUNCE_CYCLES, 4, consecutive clk cycles a new synchronized level must persist before `out` accepts it; 0 bypasses debounce.
- RESET_VALUE, {WIDTH{1'b0}}, per-channel value that every stage and `out` take during reset.

Ports:
- clk  input  1  sole clock; all outputs are registered on its rising edge.
- reset  input  1  asynchronous, active-high; asserts immediately and releases on the clock.
- in  input  WIDTH  raw asynchronous inputs, one bit per channel.
- out  output  WIDTH  debounced, synchronized levels.
- rise  output  WIDTH  one-cycle pulse when `out[i]` goes 0->1.
- fall  output  WIDTH  one-cycle pulse when `out[i]` goes 1->0.
- changed  output  1  registered OR of all `rise` and `fall` bits (single-cycle).
- glitch_count  output  16  rejected-transition counter; present only with SYNC_DEBOUNCE_GLITCH_COUNT_EN.

Behaviour:
- Reset values (reset asserted):
  - All sync stages and `out` = RESET_VALUE.
  - Debounce counters = 0.
  - `rise`, `fall`, `changed` = 0.
  - `glitch_count` = 0.
  - Mid-operation reset aborts any pending debounce; no edge pulse is generated on reset assertion or release.
- Synchronizer:
  - Stage 0 samples `in` on the falling edge of clk.
  - Stages 1..STAGES-1 register on the rising edge.
  - `s[i]` is the last stage.
  - Latency from an `in` edge to `s` is STAGES-1 cycles plus up to half a cycle.
- Debounce, per channel, on each rising edge:
  - If `s[i]` == `out[i]`: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: `out[i]` <= `s[i]`, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Result: `out` updates exactly DEBOUNCE_CYCLES cycles after `s` first differs, provided `s` holds throughout.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1); counting never wraps.
- DEBOUNCE_CYCLES = 0: `out[i]` <= `s[i]` every cycle; no counter is instantiated.
- Glitch: `s[i]` returns to `out[i]` while cnt != 0. Result: `out` unchanged and cnt cleared.
- Edge outputs, registered together with `out`:
  - `rise[i]` = 1 for the single cycle after `out[i]` transitions 0->1.
  - `fall[i]` likewise for 1->0.
  - `rise` and `fall` are never simultaneously set on one channel.
  - Channels are fully independent; simultaneous edges on several channels each pulse.
  - `changed` = |(rise|fall), registered one cycle after the pulses.
- Minimum pulse on `in` reliably passed = DEBOUNCE_CYCLES+1 cycles. Shorter pulses may or may not pass depending on sampling phase.

Optional Feature:
- Macro: SYNC_DEBOUNCE_GLITCH_COUNT_EN.
- Defined:
  - `glitch_count` port exists.
  - Incremented by 1 per cycle in which at least one channel detects a glitch; several channels in the same cycle still add 1.
  - Saturates at 16'hFFFF; cleared only by reset.
- Undefined:
  - Port and counter absent.
  - All other behaviour identical.

Test Plan:
- Reset: WIDTH=4, RESET_VALUE=4'b1010, `in`=4'b0101 held, reset asserted asynchronously mid-cycle -> `out`=4'b1010 immediately, `rise`/`fall`/`changed`=0 throughout reset, no pulse on release.
- Clean edge: DEBOUNCE_CYCLES=4, STAGES=2, `in[0]` 0->1 held -> `out[0]`=1 at 5 rising edges (+/-1) after the change, `rise[0]` high exactly 1 cycle, `changed` high the next cycle.
- Glitch reject: `in[1]` pulse of 2 cycles with DEBOUNCE_CYCLES=4 -> `out[1]` stays 0, no `rise`/`fall`, `glitch_count` increments 0->1 (macro defined).
- Bounce train: `in[2]` toggles every cycle for 10 cycles then holds 1 -> a single `rise[2]` pulse only after 4 stable cycles, `glitch_count` saturation not reached.
- Multi-channel: `in` 4'b0000->4'b1111 on the same edge -> all `rise` bits pulse in the same cycle, `changed` pulses once; with DEBOUNCE_CYCLES=0 `out` follows `s` with no counter.
- Reset mid-debounce: cnt=3 of 4 on channel 3, reset pulsed -> `out[3]`=RESET_VALUE[3], no pulse, debounce restarts from 0 after release.

Source files
------------

// File: rtl/sync_debounce.sv
// Multi-channel input conditioner: falling-edge first stage synchronizer, per-channel
// stability debounce, and registered rise/fall/changed outputs. Optional rejected-transition
// counter is enabled with the SYNC_DEBOUNCE_GLITCH_COUNT_EN macro.
module sync_debounce #(
    parameter int               WIDTH           = 1,
    parameter int               STAGES          = 2,
    parameter int               DEBOUNCE_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
`ifdef SYNC_DEBOUNCE_GLITCH_COUNT_EN
    ,
    output logic [15:0]      glitch_count
`endif
);

    localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic [WIDTH-1:0]             stage0;
    logic [STAGES-2:0][WIDTH-1:0] pipe_q;
    logic [WIDTH-1:0]             s;
    logic [WIDTH-1:0]             out_nxt;
`ifdef SYNC_DEBOUNCE_GLITCH_COUNT_EN
    logic [WIDTH-1:0]             glitch;
`endif

    // First stage on the falling edge buys half a cycle of settling before the rising-edge chain.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) stage0 <= RESET_VALUE;
        else       stage0 <= in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_q <= {(STAGES-1){RESET_VALUE}};
        end else begin
            pipe_q[0] <= stage0;
            for (int k = 1; k < STAGES - 1; k++) pipe_q[k] <= pipe_q[k-1];
        end
    end

    assign s = pipe_q[STAGES-2];

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign out_nxt[i] = s[i];
`ifdef SYNC_DEBOUNCE_GLITCH_COUNT_EN
            assign glitch[i] = 1'b0;
`endif
        end else begin : g_deb
            localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
            logic [CW-1:0] cnt;

            always_ff @(posedge clk or posedge reset) begin
                if (reset)              cnt <= '0;
                else if (s[i] == out[i]) cnt <= '0;
                else if (cnt == CMAX)   cnt <= '0;
                else                    cnt <= cnt + 1'b1;
            end

            assign out_nxt[i] = (s[i] != out[i] && cnt == CMAX) ? s[i] : out[i];
`ifdef SYNC_DEBOUNCE_GLITCH_COUNT_EN
            // A pending change that fell back before qualifying.
            assign glitch[i] = (s[i] == out[i]) && (cnt != '0);
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out     <= RESET_VALUE;
            rise    <= '0;
            fall    <= '0;
            changed <= 1'b0;
        end else begin
            out     <= out_nxt;
            rise    <= out_nxt & ~out;
            fall    <= ~out_nxt & out;
            changed <= |(rise | fall);
        end
    end

`ifdef SYNC_DEBOUNCE_GLITCH_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                     glitch_count <= '0;
        else if (|glitch && glitch_count != 16'hFFFF) glitch_count <= glitch_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// Randomized and directed bench for sync_debounce: a debounced instance and a bypass
// instance are both compared every cycle against a history-based reference model.
module tb_sync_debounce;

    localparam int         W  = 4;
    localparam logic [3:0] RV = 4'b1010;
    localparam int         D  = 4;
    localparam int         SA = 2;
    localparam int         SB = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] in = 4'b0101;
    logic [W-1:0] out_a, rise_a, fall_a, out_b, rise_b, fall_b;
    logic         changed_a, changed_b;
`ifdef SYNC_DEBOUNCE_GLITCH_COUNT_EN
    logic [15:0]  gc_a, gc_b;
`endif

    always #5 clk = ~clk;

    sync_debounce #(.WIDTH(W), .STAGES(SA), .DEBOUNCE_CYCLES(D), .RESET_VALUE(RV)) dut_a (
        .clk(clk), .reset(reset), .in(in), .out(out_a), .rise(rise_a), .fall(fall_a),
        .changed(changed_a)
`ifdef SYNC_DEBOUNCE_GLITCH_COUNT_EN
        , .glitch_count(gc_a)
`endif
    );

    sync_debounce #(.WIDTH(W), .STAGES(SB), .DEBOUNCE_CYCLES(0), .RESET_VALUE(RV)) dut_b (
        .clk(clk), .reset(reset), .in(in), .out(out_b), .rise(rise_b), .fall(fall_b),
        .changed(changed_b)
`ifdef SYNC_DEBOUNCE_GLITCH_COUNT_EN
        , .glitch_count(gc_b)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: negedge samples delayed through a queue, and "out follows s once
    // the last D pre-edge samples all disagree with out".
    logic [W-1:0] qa[$], qb[$], hist[$];
    logic [W-1:0] sa, sb, oa, ra, fa, ob, rb, fb;
    logic         ca, cb;
    int           gc;

    task automatic model_reset();
        qa.delete(); qb.delete(); hist.delete();
        for (int k = 0; k < SA - 2; k++) qa.push_back(RV);
        for (int k = 0; k < SB - 2; k++) qb.push_back(RV);
        sa = RV; sb = RV; oa = RV; ob = RV;
        ra = '0; fa = '0; rb = '0; fb = '0; ca = 1'b0; cb = 1'b0;
        gc = 0;
    endtask

    task automatic model_edge();
        logic [W-1:0] nout, prev;
        logic         any_g, stable;
        prev = (hist.size() > 0) ? hist[$] : oa;
        hist.push_back(sa);
        if (hist.size() > D) void'(hist.pop_front());
        nout  = oa;
        any_g = 1'b0;
        for (int i = 0; i < W; i++) begin
            stable = (hist.size() == D);
            foreach (hist[k]) if (hist[k][i] == oa[i]) stable = 1'b0;
            if (stable) nout[i] = sa[i];
            if (sa[i] == oa[i] && prev[i] != oa[i]) any_g = 1'b1;
        end
        ca = |(ra | fa);
        ra = nout & ~oa;
        fa = ~nout & oa;
        oa = nout;
        if (any_g && gc < 65535) gc++;
        sa = qa.pop_front();
        cb = |(rb | fb);
        rb = sb & ~ob;
        fb = ~sb & ob;
        ob = sb;
        sb = qb.pop_front();
    endtask

    task automatic check_all();
        chk("out_a", out_a, oa);
        chk("rise_a", rise_a, ra);
        chk("fall_a", fall_a, fa);
        chk("changed_a", changed_a, ca);
        chk("out_b", out_b, ob);
        chk("rise_b", rise_b, rb);
        chk("fall_b", fall_b, fb);
        chk("changed_b", changed_b, cb);
`ifdef SYNC_DEBOUNCE_GLITCH_COUNT_EN
        chk("glitch_a", gc_a, gc);
        chk("glitch_b", gc_b, 0);
`endif
    endtask

    // Inputs change just after a rising edge; the model records what the falling edge samples.
    task automatic step(input logic [W-1:0] v);
        in = v;
        @(negedge clk);
        qa.push_back(in);
        qb.push_back(in);
        @(posedge clk);
        #1;
        model_edge();
        check_all();
    endtask

    task automatic check_reset_state();
        chk("rst_out_a", out_a, RV);
        chk("rst_out_b", out_b, RV);
        chk("rst_pulses_a", {rise_a, fall_a, 3'b0, changed_a}, 0);
        chk("rst_pulses_b", {rise_b, fall_b, 3'b0, changed_b}, 0);
`ifdef SYNC_DEBOUNCE_GLITCH_COUNT_EN
        chk("rst_glitch_a", gc_a, 0);
`endif
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        #1;
        check_reset_state();
        repeat (cycles) begin
            @(posedge clk);
            #1;
            check_reset_state();
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int           lat;
        logic [W-1:0] v;

        // Asynchronous reset before the first clock edge, in opposite to RESET_VALUE.
        #2;
        do_reset(3);
        step(4'b0101);
        chk("no_pulse_release", {rise_a, fall_a}, 0);
        repeat (8) step(4'b0101);

        // Clean single-channel edge and its latency.
        repeat (8) step(4'b0000);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            step(4'b0001);
            if (lat == 0 && out_a[0]) lat = k;
        end
        chk("clean_latency", lat, 5);

        // Two-cycle pulse on channel 1 must be rejected.
        repeat (2) step(4'b0011);
        repeat (8) step(4'b0001);
        chk("glitch_out1", out_a[1], 1'b0);

        // Bounce train on channel 2, then settle high.
        for (int k = 0; k < 10; k++) step({1'b0, 1'(k % 2), 2'b01});
        repeat (8) step(4'b0101);

        // All channels change together.
        repeat (8) step(4'b0000);
        repeat (8) step(4'b1111);

        // Reset while channel 3 is three cycles into a pending change.
        repeat (4) step(4'b0111);
        #2;
        do_reset(2);
        repeat (10) step(4'b0111);

        // Random input with slow bit flips so both glitches and accepted changes occur.
        v = 4'b0111;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < W; i++) if ($urandom_range(5) == 0) v[i] = ~v[i];
            step(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
